// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions: LEGv8 opcode encodings, decode masks and FSM states.
package cpu_ctrl_pkg;

    localparam int unsigned OPC_W    = 11;
    localparam int unsigned ZERO_REG = 31;

    // Opcode values, left-aligned in the 11-bit field; compare after masking.
    localparam logic [OPC_W-1:0] OP_ADD  = 11'b100_0101_1000;
    localparam logic [OPC_W-1:0] OP_ADDS = 11'b101_0101_1000;
    localparam logic [OPC_W-1:0] OP_SUB  = 11'b110_0101_1000;
    localparam logic [OPC_W-1:0] OP_SUBS = 11'b111_0101_1000;
    localparam logic [OPC_W-1:0] OP_AND  = 11'b100_0101_0000;
    localparam logic [OPC_W-1:0] OP_EOR  = 11'b110_0101_0000;
    localparam logic [OPC_W-1:0] OP_ADDI = 11'b100_1000_1000;
    localparam logic [OPC_W-1:0] OP_LDUR = 11'b111_1100_0010;
    localparam logic [OPC_W-1:0] OP_STUR = 11'b111_1100_0000;
    localparam logic [OPC_W-1:0] OP_CBZ  = 11'b101_1010_0000;
    localparam logic [OPC_W-1:0] OP_BR   = 11'b110_1011_0000;
    localparam logic [OPC_W-1:0] OP_B    = 11'b000_1010_0000;
    localparam logic [OPC_W-1:0] OP_BL   = 11'b100_1010_0000;
    localparam logic [OPC_W-1:0] OP_BLT  = 11'b010_1010_0000;

    // Significant opcode bits per instruction format.
    localparam logic [OPC_W-1:0] MASK_R  = 11'h7FF;
    localparam logic [OPC_W-1:0] MASK_I  = 11'h7FE;
    localparam logic [OPC_W-1:0] MASK_CB = 11'h7F8;
    localparam logic [OPC_W-1:0] MASK_B  = 11'h7E0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        SQUASH = 2'd2
    } ctrl_state_t;

    function automatic logic op_is(input logic [OPC_W-1:0] opc,
                                   input logic [OPC_W-1:0] val,
                                   input logic [OPC_W-1:0] mask);
        return (opc & mask) == val;
    endfunction

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// ID/EX/MEM hazard inputs and pipeline-control outputs of the sequencing controller.
interface branch_hazard_ctrl_if #(
    parameter int unsigned REG_W  = 5,
    parameter int unsigned PERF_W = 32
);
    logic              id_valid;
    logic [10:0]       id_opcode;
    logic [REG_W-1:0]  id_rn;
    logic [REG_W-1:0]  id_rm;
    logic [REG_W-1:0]  id_rt;
    logic              ex_reg_wr;
    logic              ex_mem_rd;
    logic [REG_W-1:0]  ex_rd;
    logic              mem_mem_rd;
    logic [REG_W-1:0]  mem_rd;
    logic              br_taken;
    logic              uncond_br;
    logic              pc_rd;

    logic              pc_wr_en;
    logic              ifid_wr_en;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              redirect;
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;
    logic              hazard_err;

    modport master (
        output id_valid, id_opcode, id_rn, id_rm, id_rt,
               ex_reg_wr, ex_mem_rd, ex_rd, mem_mem_rd, mem_rd,
               br_taken, uncond_br, pc_rd,
        input  pc_wr_en, ifid_wr_en, ifid_flush, idex_bubble, redirect,
               stall_cnt, flush_cnt, hazard_err
    );

    modport slave (
        input  id_valid, id_opcode, id_rn, id_rm, id_rt,
               ex_reg_wr, ex_mem_rd, ex_rd, mem_mem_rd, mem_rd,
               br_taken, uncond_br, pc_rd,
        output pc_wr_en, ifid_wr_en, ifid_flush, idex_bubble, redirect,
               stall_cnt, flush_cnt, hazard_err
    );

endinterface

// File: rtl/src_use_decode.sv
// Opcode -> which register fields the ID instruction reads, and whether it is a register branch.
module src_use_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output logic             uses_rn_o,
    output logic             uses_rm_o,
    output logic             uses_rt_o,
    output logic             is_reg_branch_o
);

    // Format decode; anything not listed reads no registers.
    always_comb begin
        uses_rn_o       = 1'b0;
        uses_rm_o       = 1'b0;
        uses_rt_o       = 1'b0;
        is_reg_branch_o = 1'b0;
        if (op_is(opcode_i, OP_ADD,  MASK_R) || op_is(opcode_i, OP_ADDS, MASK_R) ||
            op_is(opcode_i, OP_SUB,  MASK_R) || op_is(opcode_i, OP_SUBS, MASK_R) ||
            op_is(opcode_i, OP_AND,  MASK_R) || op_is(opcode_i, OP_EOR,  MASK_R)) begin
            uses_rn_o = 1'b1;
            uses_rm_o = 1'b1;
        end else if (op_is(opcode_i, OP_ADDI, MASK_I) || op_is(opcode_i, OP_LDUR, MASK_R)) begin
            uses_rn_o = 1'b1;
        end else if (op_is(opcode_i, OP_STUR, MASK_R)) begin
            uses_rn_o = 1'b1;
            uses_rt_o = 1'b1;
        end else if (op_is(opcode_i, OP_CBZ, MASK_CB)) begin
            uses_rt_o       = 1'b1;
            is_reg_branch_o = 1'b1;
        end else if (op_is(opcode_i, OP_BR, MASK_R)) begin
            uses_rn_o       = 1'b1;
            is_reg_branch_o = 1'b1;
        end else if (op_is(opcode_i, OP_B, MASK_B) || op_is(opcode_i, OP_BL, MASK_B) ||
                     op_is(opcode_i, OP_BLT, MASK_CB)) begin
            // Immediate-target branches read no registers.
            uses_rn_o = 1'b0;
        end
    end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Pipeline sequencing controller: load-use / branch-operand stalls, redirect squash,
// saturating perf counters and a stall-run watchdog.
module branch_hazard_ctrl #(
    parameter int unsigned REG_W     = 5,
    parameter int unsigned PERF_W    = 32,
    parameter int unsigned ZERO_REG  = cpu_ctrl_pkg::ZERO_REG,
    parameter int unsigned MAX_STALL = 2
) (
    input  logic               clk,
    input  logic               reset,
    branch_hazard_ctrl_if.slave bus
);
    import cpu_ctrl_pkg::*;

    localparam int unsigned RUN_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

    ctrl_state_t       state_q, state_d;
    logic [RUN_W-1:0]  stall_run_q, stall_run_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;
    logic              hazard_err_q, hazard_err_d;

    logic uses_rn_c, uses_rm_c, uses_rt_c, is_reg_branch_c;
    logic hit_ex_c, hit_mem_c;
    logic v_c, stall_c, redirect_c;
    logic pc_wr_en_c, ifid_wr_en_c, ifid_flush_c, idex_bubble_c;
    logic unused_uncond;

    // uncond_br is already folded into br_taken by the branch unit.
    assign unused_uncond = bus.uncond_br;

    src_use_decode u_decode (
        .opcode_i        (bus.id_opcode),
        .uses_rn_o       (uses_rn_c),
        .uses_rm_o       (uses_rm_c),
        .uses_rt_o       (uses_rt_c),
        .is_reg_branch_o (is_reg_branch_c)
    );

    // Source-vs-destination comparators; XZR never produces a dependency.
    always_comb begin
        hit_ex_c  = (bus.ex_rd != REG_W'(ZERO_REG)) &&
                    ((uses_rn_c && (bus.id_rn == bus.ex_rd)) ||
                     (uses_rm_c && (bus.id_rm == bus.ex_rd)) ||
                     (uses_rt_c && (bus.id_rt == bus.ex_rd)));
        hit_mem_c = (bus.mem_rd != REG_W'(ZERO_REG)) &&
                    ((uses_rn_c && (bus.id_rn == bus.mem_rd)) ||
                     (uses_rm_c && (bus.id_rm == bus.mem_rd)) ||
                     (uses_rt_c && (bus.id_rt == bus.mem_rd)));
    end

    // Hazard and redirect decisions; a stall always wins over a redirect.
    always_comb begin
        v_c        = bus.id_valid && (state_q != SQUASH);
        stall_c    = v_c && ((bus.ex_mem_rd && hit_ex_c) ||
                             (is_reg_branch_c && bus.ex_reg_wr && !bus.ex_mem_rd && hit_ex_c) ||
                             (is_reg_branch_c && bus.mem_mem_rd && hit_mem_c));
        redirect_c = v_c && !stall_c && (bus.br_taken || bus.pc_rd);
    end

    // Pipeline control strobes for the current cycle.
    always_comb begin
        pc_wr_en_c    = 1'b1;
        ifid_wr_en_c  = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        if (state_q == SQUASH) begin
            idex_bubble_c = 1'b1;
        end
        if (stall_c) begin
            pc_wr_en_c    = 1'b0;
            ifid_wr_en_c  = 1'b0;
            idex_bubble_c = 1'b1;
        end
        if (redirect_c) begin
            ifid_flush_c = 1'b1;
        end
    end

    assign bus.pc_wr_en    = pc_wr_en_c;
    assign bus.ifid_wr_en  = ifid_wr_en_c;
    assign bus.ifid_flush  = ifid_flush_c;
    assign bus.idex_bubble = idex_bubble_c;
    assign bus.redirect    = redirect_c;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;
    assign bus.hazard_err  = hazard_err_q;

    // Next state, saturating counters and watchdog.
    always_comb begin
        state_d      = RUN;
        stall_run_d  = '0;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        hazard_err_d = hazard_err_q;
        if (stall_c) begin
            state_d = STALL;
        end else if (redirect_c) begin
            state_d = SQUASH;
        end
        if (stall_c) begin
            stall_run_d = (stall_run_q >= RUN_W'(MAX_STALL)) ? stall_run_q
                                                             : stall_run_q + RUN_W'(1);
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + PERF_W'(1);
            end
            if (stall_run_q >= RUN_W'(MAX_STALL)) begin
                hazard_err_d = 1'b1;
            end
        end
        if (redirect_c && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + PERF_W'(1);
        end
    end

    // State and counter registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            stall_run_q  <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            hazard_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            stall_run_q  <= stall_run_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            hazard_err_q <= hazard_err_d;
        end
    end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Cycle-by-cycle vector table for the hazard controller plus counter saturation sequences.
module tb_branch_hazard_ctrl;
    import cpu_ctrl_pkg::*;

    // Expected strobes packed as {pc_wr_en, ifid_wr_en, ifid_flush, idex_bubble, redirect}.
    localparam logic [4:0] E_RUN   = 5'b11000;
    localparam logic [4:0] E_STALL = 5'b00010;
    localparam logic [4:0] E_REDIR = 5'b11101;
    localparam logic [4:0] E_SQ    = 5'b11010;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [10:0] op;
        logic [4:0]  rn, rm, rt;
        logic        exw, exl;
        logic [4:0]  exrd;
        logic        meml;
        logic [4:0]  memrd;
        logic        bt, pcrd;
        logic [4:0]  ctl;
        int unsigned sc, fc;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    branch_hazard_ctrl_if #(.REG_W(5), .PERF_W(32)) bus ();
    branch_hazard_ctrl_if #(.REG_W(5), .PERF_W(4))  bus4 ();

    branch_hazard_ctrl #(.REG_W(5), .PERF_W(32), .ZERO_REG(31), .MAX_STALL(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    branch_hazard_ctrl #(.REG_W(5), .PERF_W(4), .ZERO_REG(31), .MAX_STALL(2)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic valid, input logic [10:0] op,
                                input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rt,
                                input logic exw, input logic exl, input logic [4:0] exrd,
                                input logic meml, input logic [4:0] memrd,
                                input logic bt, input logic pcrd,
                                input logic [4:0] ctl, input int unsigned sc,
                                input int unsigned fc, input logic err);
        vec_t v;
        v.rst = rst; v.valid = valid; v.op = op; v.rn = rn; v.rm = rm; v.rt = rt;
        v.exw = exw; v.exl = exl; v.exrd = exrd; v.meml = meml; v.memrd = memrd;
        v.bt = bt; v.pcrd = pcrd; v.ctl = ctl; v.sc = sc; v.fc = fc; v.err = err;
        return v;
    endfunction

    function automatic vec_t idle(input logic rst, input logic [4:0] ctl, input int unsigned sc,
                                  input int unsigned fc, input logic err);
        return mk(rst, 1'b0, 11'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,
                  1'b0, 1'b0, ctl, sc, fc, err);
    endfunction

    task automatic drive(input vec_t v);
        reset          = v.rst;
        bus.id_valid   = v.valid;
        bus.id_opcode  = v.op;
        bus.id_rn      = v.rn;
        bus.id_rm      = v.rm;
        bus.id_rt      = v.rt;
        bus.ex_reg_wr  = v.exw;
        bus.ex_mem_rd  = v.exl;
        bus.ex_rd      = v.exrd;
        bus.mem_mem_rd = v.meml;
        bus.mem_rd     = v.memrd;
        bus.br_taken   = v.bt;
        bus.uncond_br  = v.bt && (v.op == OP_B);
        bus.pc_rd      = v.pcrd;
    endtask

    task automatic idle4();
        bus4.id_valid = 1'b0; bus4.id_opcode = 11'h0;
        bus4.id_rn = 5'd0; bus4.id_rm = 5'd0; bus4.id_rt = 5'd0;
        bus4.ex_reg_wr = 1'b0; bus4.ex_mem_rd = 1'b0; bus4.ex_rd = 5'd0;
        bus4.mem_mem_rd = 1'b0; bus4.mem_rd = 5'd0;
        bus4.br_taken = 1'b0; bus4.uncond_br = 1'b0; bus4.pc_rd = 1'b0;
    endtask

    task automatic check(input string name, input int unsigned got, input int unsigned want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        vec_t e;
        logic [4:0] act;

        // Reset state, then single-cycle load-use stall on an ALU consumer.
        vecs.push_back(idle(0, E_RUN, 0, 0, 0));                                              // 0
        vecs.push_back(mk(0,1,OP_ADD, 1,3,0, 1,1,1, 0,0, 0,0, E_STALL,0,0,0));              // 1
        vecs.push_back(mk(0,1,OP_ADD, 1,3,0, 0,0,0, 1,1, 0,0, E_RUN,  1,0,0));              // 2
        vecs.push_back(idle(0, E_RUN, 1, 0, 0));                                              // 3
        // LDUR then CBZ on its Rd: two stalls, redirect, squash.
        vecs.push_back(mk(0,1,OP_CBZ, 0,0,2, 1,1,2, 0,0, 1,0, E_STALL,1,0,0));              // 4
        vecs.push_back(mk(0,1,OP_CBZ, 0,0,2, 0,0,0, 1,2, 1,0, E_STALL,2,0,0));              // 5
        vecs.push_back(mk(0,1,OP_CBZ, 0,0,2, 0,0,0, 0,0, 1,0, E_REDIR,3,0,0));              // 6
        vecs.push_back(mk(0,1,OP_ADD, 0,0,0, 0,0,0, 0,0, 1,0, E_SQ,   3,1,0));              // 7
        vecs.push_back(idle(0, E_RUN, 3, 1, 0));                                              // 8
        // BR without hazard redirects at once; the squash cycle ignores a taken branch.
        vecs.push_back(mk(0,1,OP_BR,  7,0,0, 1,0,9, 0,0, 0,1, E_REDIR,3,1,0));              // 9
        vecs.push_back(mk(0,1,OP_B,   0,0,0, 0,0,0, 0,0, 1,0, E_SQ,   3,2,0));              // 10
        vecs.push_back(idle(0, E_RUN, 3, 2, 0));                                              // 11
        // XZR destination, ALU producer for reg-branch vs ALU consumer, STUR data reg.
        vecs.push_back(mk(0,1,OP_ADD, 31,31,0, 1,1,31, 0,0, 0,0, E_RUN,3,2,0));             // 12
        vecs.push_back(mk(0,1,OP_CBZ, 0,0,5, 1,0,5, 0,0, 0,0, E_STALL,3,2,0));              // 13
        vecs.push_back(mk(0,1,OP_ADD, 5,0,0, 1,0,5, 0,0, 0,0, E_RUN,  4,2,0));              // 14
        vecs.push_back(mk(0,1,OP_STUR,2,0,6, 1,1,6, 0,0, 0,0, E_STALL,4,2,0));              // 15
        vecs.push_back(idle(0, E_RUN, 5, 2, 0));                                              // 16
        // Unknown opcode and id_valid=0 never stall or redirect.
        vecs.push_back(mk(0,1,11'h000,4,4,4, 1,1,4, 0,0, 0,0, E_RUN,5,2,0));                // 17
        vecs.push_back(mk(0,0,OP_ADD, 1,0,0, 1,1,1, 0,0, 1,0, E_RUN,5,2,0));                // 18
        // Stall dominates a taken branch; re-resolved after release.
        vecs.push_back(mk(0,1,OP_CBZ, 0,0,8, 1,0,8, 0,0, 1,0, E_STALL,5,2,0));              // 19
        vecs.push_back(mk(0,1,OP_CBZ, 0,0,8, 0,0,0, 0,0, 1,0, E_REDIR,6,2,0));              // 20
        vecs.push_back(idle(0, E_SQ, 6, 3, 0));                                               // 21
        // Watchdog: third consecutive stall sets the sticky error; reset mid-stall clears.
        vecs.push_back(mk(0,1,OP_ADD, 1,0,0, 1,1,1, 0,0, 0,0, E_STALL,6,3,0));              // 22
        vecs.push_back(mk(0,1,OP_ADD, 1,0,0, 1,1,1, 0,0, 0,0, E_STALL,7,3,0));              // 23
        vecs.push_back(mk(0,1,OP_ADD, 1,0,0, 1,1,1, 0,0, 0,0, E_STALL,8,3,0));              // 24
        vecs.push_back(mk(0,1,OP_ADD, 1,0,0, 1,1,1, 0,0, 0,0, E_STALL,9,3,1));              // 25
        vecs.push_back(mk(1,1,OP_ADD, 1,0,0, 1,1,1, 0,0, 0,0, E_STALL,10,3,1));             // 26
        vecs.push_back(idle(0, E_RUN, 0, 0, 0));                                              // 27
        // Reset during the squash cycle.
        vecs.push_back(mk(0,1,OP_BR,  7,0,0, 0,0,0, 0,0, 0,1, E_REDIR,0,0,0));              // 28
        vecs.push_back(idle(1, E_SQ, 0, 1, 0));                                               // 29
        vecs.push_back(idle(0, E_RUN, 0, 0, 0));                                              // 30
        // XZR on the MEM load, ADDI ignores Rm, EOR uses Rm.
        vecs.push_back(mk(0,1,OP_CBZ, 0,0,31, 0,0,0, 1,31, 0,0, E_RUN,0,0,0));              // 31
        vecs.push_back(mk(0,1,OP_ADDI,0,9,0, 1,1,9, 0,0, 0,0, E_RUN,0,0,0));                // 32
        vecs.push_back(mk(0,1,OP_ADDI,9,0,0, 1,1,9, 0,0, 0,0, E_STALL,0,0,0));              // 33
        vecs.push_back(idle(0, E_RUN, 1, 0, 0));                                              // 34
        vecs.push_back(mk(0,1,OP_EOR, 0,12,0, 1,1,12, 0,0, 0,0, E_STALL,1,0,0));            // 35
        vecs.push_back(idle(0, E_RUN, 2, 0, 0));                                              // 36

        idle4();
        drive(idle(1, E_RUN, 0, 0, 0));
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            e   = exp_q.pop_front();
            act = {bus.pc_wr_en, bus.ifid_wr_en, bus.ifid_flush, bus.idex_bubble, bus.redirect};
            n_vec++;
            if (act !== e.ctl) begin
                n_bad++;
                $display("FAIL vec%0d ctl: got %b want %b", i, act, e.ctl);
            end
            n_vec++;
            if (bus.stall_cnt !== 32'(e.sc) || bus.flush_cnt !== 32'(e.fc)) begin
                n_bad++;
                $display("FAIL vec%0d counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                         i, bus.stall_cnt, bus.flush_cnt, e.sc, e.fc);
            end
            n_vec++;
            if (bus.hazard_err !== e.err) begin
                n_bad++;
                $display("FAIL vec%0d hazard_err: got %b want %b", i, bus.hazard_err, e.err);
            end
        end

        // Narrow counters: a long stall run saturates stall_cnt at 15.
        @(posedge clk);
        #1;
        drive(idle(0, E_RUN, 0, 0, 0));
        bus4.id_valid = 1'b1; bus4.id_opcode = OP_ADD; bus4.id_rn = 5'd1;
        bus4.ex_reg_wr = 1'b1; bus4.ex_mem_rd = 1'b1; bus4.ex_rd = 5'd1;
        repeat (14) @(posedge clk);
        #1;
        check("sat stall_cnt after 14", 32'(bus4.stall_cnt), 14);
        repeat (6) @(posedge clk);
        #1;
        check("sat stall_cnt held", 32'(bus4.stall_cnt), 15);
        check("sat hazard_err", 32'(bus4.hazard_err), 1);

        // Back-to-back BR redirects alternate with squash cycles; flush_cnt saturates.
        bus4.ex_reg_wr = 1'b0; bus4.ex_mem_rd = 1'b0; bus4.ex_rd = 5'd0;
        bus4.id_opcode = OP_BR; bus4.id_rn = 5'd3; bus4.pc_rd = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        check("sat flush_cnt after 14", 32'(bus4.flush_cnt), 7);
        repeat (26) @(posedge clk);
        #1;
        check("sat flush_cnt held", 32'(bus4.flush_cnt), 15);
        check("sat stall_cnt unchanged", 32'(bus4.stall_cnt), 15);
        idle4();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
